vga_scene: RTL



---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_timing.sv | 54 +++++
 rtl/vga_scene.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 timing, scene colours, shadow-register layout        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package vga_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [11:0] BG    = 12'h000;
    localparam logic [11:0] OBJ   = 12'hFF0;
    localparam logic [11:0] PLY   = 12'h0F0;
    localparam logic [11:0] END   = 12'hF00;
    localparam logic [11:0] SCORE = 12'h0FF;
    localparam logic [11:0] MISS  = 12'hF0F;

    typedef struct packed {
        logic [11:0] x_begin;
        logic [11:0] y_begin;
        logic [11:0] p_x;
        logic [3:0]  score;
        logic [3:0]  miss;
        logic        end_show;
    } frame_regs_t;

    // 13-bit span test: start+len cannot wrap for any 12-bit start.
    function automatic logic in_span(input logic [12:0] pos,
                                     input logic [12:0] start,
                                     input logic [12:0] len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing : /4 pixel enable, h/v counters, sync decode, visible flag     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       pe,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       visible,
    output logic       hsync_pre,
    output logic       vsync_pre
);

    logic [1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    assign pe = (div == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (pe) begin
            if (h == H_TOTAL - 10'd1) begin
                h <= 10'd0;
                if (v == V_TOTAL - 10'd1) begin
                    v <= 10'd0;
                end else begin
                    v <= v + 10'd1;
                end
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    assign visible   = (h < H_VISIBLE) && (v < V_VISIBLE);
    assign hsync_pre = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    assign vsync_pre = !((v >= V_SYNC_START) && (v < V_SYNC_END));

endmodule
`default_nettype wire

// File: rtl/vga_scene.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_scene : per-frame input latch, sprite hit tests, colour priority mux  |
// | Optional score/miss bars: define VGA_SCORE_BAR_EN                          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vga_scene
    import vga_pkg::*;
#(
    parameter int OBJ_W  = 40,
    parameter int OBJ_H  = 40,
    parameter int PLY_W  = 100,
    parameter int PLY_Y0 = 380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] x_begin,
    input  logic [11:0] y_begin,
    input  logic [11:0] p_x,
    input  logic [3:0]  score,
    input  logic [3:0]  miss,
    input  logic        end_show,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam logic [12:0] OBJ_W13  = 13'(OBJ_W);
    localparam logic [12:0] OBJ_H13  = 13'(OBJ_H);
    localparam logic [12:0] PLY_W13  = 13'(PLY_W);
    localparam logic [12:0] PLY_Y013 = 13'(PLY_Y0);
    localparam logic [12:0] PLY_H13  = 13'd20;

    logic        pe;
    logic        visible;
    logic        hsync_pre;
    logic        vsync_pre;
    logic [9:0]  h;
    logic [9:0]  v;

    vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .pe        (pe),
        .h         (h),
        .v         (v),
        .visible   (visible),
        .hsync_pre (hsync_pre),
        .vsync_pre (vsync_pre)
    );

    // Latch at the start of vertical blanking so a frame never mixes positions.
    logic        latch_now;
    frame_regs_t shadow;

    assign latch_now = pe && (h == 10'd0) && (v == V_VISIBLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch_now;
            if (latch_now) begin
                shadow.x_begin  <= x_begin;
                shadow.y_begin  <= y_begin;
                shadow.p_x      <= p_x;
                shadow.score    <= score;
                shadow.miss     <= miss;
                shadow.end_show <= end_show;
            end
        end
    end

    logic [12:0] h13;
    logic [12:0] v13;
    logic        obj_hit;
    logic        ply_hit;

    assign h13     = {3'b000, h};
    assign v13     = {3'b000, v};
    assign obj_hit = in_span(h13, {1'b0, shadow.x_begin}, OBJ_W13) &&
                     in_span(v13, {1'b0, shadow.y_begin}, OBJ_H13);
    assign ply_hit = in_span(h13, {1'b0, shadow.p_x}, PLY_W13) &&
                     in_span(v13, PLY_Y013, PLY_H13);

`ifdef VGA_SCORE_BAR_EN
    logic score_hit;
    logic miss_hit;

    // Each point is a 16-pixel segment; a count of zero yields an empty bar.
    assign score_hit = (v < 10'd8) && (h13 < {5'b00000, shadow.score, 4'b0000});
    assign miss_hit  = (v >= 10'd8) && (v < 10'd16) &&
                       (h13 < {5'b00000, shadow.miss, 4'b0000});
`else
    logic unused_bars;
    assign unused_bars = ^{shadow.score, shadow.miss};
`endif

    logic [11:0] pix;

    always_comb begin
        pix = 12'h000;
        if (visible) begin
            if (shadow.end_show) begin
                pix = END;
            end else if (ply_hit) begin
                pix = PLY;
            end else if (obj_hit) begin
                pix = OBJ;
            end else begin
                pix = BG;
            end
`ifdef VGA_SCORE_BAR_EN
            if (score_hit) begin
                pix = SCORE;
            end else if (miss_hit) begin
                pix = MISS;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 12'h000;
        end else if (pe) begin
            hsync <= hsync_pre;
            vsync <= vsync_pre;
            rgb   <= pix;
        end
    end

endmodule
`default_nettype wire
